keypress_decoder: RTL and testbench
===================================

KEYPRESS_DECODER -- requirements
Module: keypress_decoder

Interface
REQ-001 Parameter CHAR_WIDTH, default 16, width of emitted character code.
REQ-002 Parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, >=2.
REQ-003 Parameter UPPER_OFFSET, default 64, added to letter codes 1-26 when uppercase.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000, prefix-state abandon limit.
REQ-005 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-high.
REQ-007 byte_in  input  8  PS/2 scancode byte from the receiver.
REQ-008 byte_valid_in  input  1  single-cycle strobe qualifying byte_in.
REQ-009 char_out  output  CHAR_WIDTH  head-of-FIFO character code.
REQ-010 char_valid_out  output  1  FIFO non-empty; char_out valid.
REQ-011 char_ready_in  input  1  consumer pops head when char_valid_out & char_ready_in.
REQ-012 overflow_out  output  1  one-cycle pulse when a char is dropped because the FIFO is full.
REQ-013 shift_out  output  1  either shift key currently held.
REQ-014 caps_out  output  1  caps-lock latched state.
REQ-015 count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Parser FSM states SHALL be IDLE, BREAK, EXT, EXT_BREAK; only byte_valid_in cycles advance it.
REQ-017 IDLE: 0xF0->BREAK; 0xE0->EXT; any other byte is a normal make code, stay IDLE.
REQ-018 EXT: 0xF0->EXT_BREAK; any other byte is an extended make code, ->IDLE.
REQ-019 BREAK/EXT_BREAK: any byte is a (normal/extended) break code, ->IDLE.
REQ-020 In BREAK, EXT, EXT_BREAK, a counter SHALL return the FSM to IDLE after TIMEOUT_CYCLES cycles with no byte_valid_in; counter clears on every accepted byte.
REQ-021 Make 0x12 sets shift_l, make 0x59 sets shift_r; matching break codes clear them; shift_out = shift_l | shift_r; no char emitted.
REQ-022 Make 0x58 toggles caps only if caps_held is 0, then sets caps_held; break 0x58 clears caps_held; typematic repeats do not retoggle; no char emitted.
REQ-023 Normal make codes SHALL translate with the existing sprite table: letters 1-26 (a=1..z=26), digits 1-9 -> 35-43, 0 -> 44, 0x54->29, 0x5B->30, comma->32, period->33, slash->47, space->0, enter->48, backspace->27, 0x05->49, 0x06->50.
REQ-024 Letter code L SHALL be emitted as L+UPPER_OFFSET when shift_out XOR caps_out, else L.
REQ-025 Slash (0x4A) with shift_out SHALL emit 31; caps does not affect non-letters.
REQ-026 Extended make 0xE0 0x75 (up) SHALL emit 49; 0xE0 0x72 (down) SHALL emit 50; other extended makes emit nothing.
REQ-027 Unmapped make codes and all break codes SHALL emit nothing.
REQ-028 Typematic repeat makes of mapped keys SHALL emit each time.
REQ-029 Translation is registered: byte sampled at edge E -> entry written at edge E+1 -> char_valid_out high after E+1 (2-cycle latency into empty FIFO).
REQ-030 FIFO SHALL be first-word-fall-through; char_out stable while char_valid_out & !char_ready_in.
REQ-031 Push when full without simultaneous pop: char dropped, overflow_out pulses, contents unchanged.
REQ-032 Push and pop same cycle when full: both occur, no overflow, count unchanged.
REQ-033 Push and pop same cycle when empty: pop ignored (nothing valid), push stored, count=1.
REQ-034 Read/write pointers wrap modulo FIFO_DEPTH; count_out never exceeds FIFO_DEPTH.
REQ-035 char_out value when char_valid_out=0 is don't-care.

Reset
REQ-036 rst_in high at an edge SHALL set FSM=IDLE, timeout counter=0, shift_l=shift_r=caps=caps_held=0, pointers=0, translation stage empty.
REQ-037 After reset: char_valid_out=0, count_out=0, overflow_out=0, shift_out=0, caps_out=0.
REQ-038 Reset mid-sequence (e.g. after 0xE0 or 0xF0) discards the prefix and any in-flight translation; no char emitted.
REQ-039 byte_valid_in during rst_in is ignored.

Verification
REQ-040 Byte 0x1C -> char_out=1, char_valid_out rises 2 cycles after strobe; pop -> count_out=0.
REQ-041 0x12, 0x1C, 0xF0 0x12, 0x1C -> chars 65 then 1; shift_out high only between shift make and break.
REQ-042 0x58, 0x58 (repeat), 0xF0 0x58, 0x15 -> caps_out=1, single toggle, char 81; with shift held also -> char 17.
REQ-043 0xE0 0x75, 0xF0 0x1C, 0xE0 0xF0 0x75 -> exactly one char 49; break codes emit nothing.
REQ-044 FIFO_DEPTH+1 makes of 0x16 with char_ready_in=0 -> count_out=FIFO_DEPTH, one overflow_out pulse; then full push with simultaneous pop -> no overflow, order preserved (all 35).
REQ-045 0xF0, idle TIMEOUT_CYCLES, then 0x1C -> char 1 emitted (FSM returned to IDLE); 0xE0 then rst_in, then 0x75 -> no char emitted.

Source files
------------

// File: rtl/keypress_decoder.sv
// PS/2 scancode to character-code decoder with shift/caps tracking and FWFT output FIFO.
// Ports: clk_in/rst_in, byte_in+byte_valid_in in; char_out/char_valid_out/char_ready_in, overflow_out, shift_out, caps_out, count_out.
module keypress_decoder #(
  parameter int CHAR_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int UPPER_OFFSET   = 64,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid_in,
  output logic [CHAR_WIDTH-1:0]         char_out,
  output logic                          char_valid_out,
  input  logic                          char_ready_in,
  output logic                          overflow_out,
  output logic                          shift_out,
  output logic                          caps_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tmo;
  logic            w_tmo_hit;
  logic            w_nmake;
  logic            w_nbrk;
  logic            w_xmake;

  logic            r_shift_l;
  logic            r_shift_r;
  logic            r_caps;
  logic            r_caps_held;

  logic            w_hit;
  logic [5:0]      w_code;
  logic            w_letter;
  logic [CHAR_WIDTH-1:0] w_char;

  logic            r_xl_valid;
  logic [CHAR_WIDTH-1:0] r_xl_char;

  logic [CHAR_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // Prefix states give up after a long silence so a lost byte
  // cannot swallow the next real keystroke.
  assign w_tmo_hit = (r_state != S_IDLE) && !byte_valid_in &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || byte_valid_in || r_state == S_IDLE || w_tmo_hit)
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + TW'(1);
  end

  always_comb begin
    w_next = r_state;
    if (byte_valid_in) begin
      unique case (r_state)
        S_IDLE: begin
          if (byte_in == 8'hF0)      w_next = S_BREAK;
          else if (byte_in == 8'hE0) w_next = S_EXT;
        end
        S_EXT: begin
          if (byte_in == 8'hF0) w_next = S_EXT_BREAK;
          else                  w_next = S_IDLE;
        end
        S_BREAK:     w_next = S_IDLE;
        S_EXT_BREAK: w_next = S_IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    w_nmake = 1'b0;
    w_nbrk  = 1'b0;
    w_xmake = 1'b0;
    if (byte_valid_in) begin
      case (r_state)
        S_IDLE:  w_nmake = (byte_in != 8'hF0) && (byte_in != 8'hE0);
        S_EXT:   w_xmake = (byte_in != 8'hF0);
        S_BREAK: w_nbrk  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (w_nmake) begin
      if (byte_in == 8'h12) r_shift_l <= 1'b1;
      if (byte_in == 8'h59) r_shift_r <= 1'b1;
      if (byte_in == 8'h58) begin
        // Typematic repeats arrive while held; only the first press toggles.
        if (!r_caps_held) r_caps <= ~r_caps;
        r_caps_held <= 1'b1;
      end
    end else if (w_nbrk) begin
      if (byte_in == 8'h12) r_shift_l   <= 1'b0;
      if (byte_in == 8'h59) r_shift_r   <= 1'b0;
      if (byte_in == 8'h58) r_caps_held <= 1'b0;
    end
  end

  assign shift_out = r_shift_l | r_shift_r;
  assign caps_out  = r_caps;

  always_comb begin
    w_hit  = 1'b0;
    w_code = 6'd0;
    if (w_nmake) begin
      w_hit = 1'b1;
      case (byte_in)
        8'h1C: w_code = 6'd1;   8'h32: w_code = 6'd2;
        8'h21: w_code = 6'd3;   8'h23: w_code = 6'd4;
        8'h24: w_code = 6'd5;   8'h2B: w_code = 6'd6;
        8'h34: w_code = 6'd7;   8'h33: w_code = 6'd8;
        8'h43: w_code = 6'd9;   8'h3B: w_code = 6'd10;
        8'h42: w_code = 6'd11;  8'h4B: w_code = 6'd12;
        8'h3A: w_code = 6'd13;  8'h31: w_code = 6'd14;
        8'h44: w_code = 6'd15;  8'h4D: w_code = 6'd16;
        8'h15: w_code = 6'd17;  8'h2D: w_code = 6'd18;
        8'h1B: w_code = 6'd19;  8'h2C: w_code = 6'd20;
        8'h3C: w_code = 6'd21;  8'h2A: w_code = 6'd22;
        8'h1D: w_code = 6'd23;  8'h22: w_code = 6'd24;
        8'h35: w_code = 6'd25;  8'h1A: w_code = 6'd26;
        8'h16: w_code = 6'd35;  8'h1E: w_code = 6'd36;
        8'h26: w_code = 6'd37;  8'h25: w_code = 6'd38;
        8'h2E: w_code = 6'd39;  8'h36: w_code = 6'd40;
        8'h3D: w_code = 6'd41;  8'h3E: w_code = 6'd42;
        8'h46: w_code = 6'd43;  8'h45: w_code = 6'd44;
        8'h54: w_code = 6'd29;  8'h5B: w_code = 6'd30;
        8'h41: w_code = 6'd32;  8'h49: w_code = 6'd33;
        8'h4A: w_code = shift_out ? 6'd31 : 6'd47;
        8'h29: w_code = 6'd0;   8'h5A: w_code = 6'd48;
        8'h66: w_code = 6'd27;  8'h05: w_code = 6'd49;
        8'h06: w_code = 6'd50;
        default: w_hit = 1'b0;
      endcase
    end else if (w_xmake) begin
      if (byte_in == 8'h75) begin
        w_hit  = 1'b1;
        w_code = 6'd49;
      end else if (byte_in == 8'h72) begin
        w_hit  = 1'b1;
        w_code = 6'd50;
      end
    end
  end

  // Only letters occupy codes 1..26 in the table.
  assign w_letter = (w_code >= 6'd1) && (w_code <= 6'd26);

  always_comb begin
    w_char = CHAR_WIDTH'(w_code);
    if (w_letter && (shift_out ^ caps_out))
      w_char = CHAR_WIDTH'(w_code) + CHAR_WIDTH'(UPPER_OFFSET);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_xl_valid <= 1'b0;
      r_xl_char  <= '0;
    end else begin
      r_xl_valid <= w_hit;
      r_xl_char  <= w_char;
    end
  end

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && char_ready_in;
  assign w_push = r_xl_valid && (!w_full || w_pop);
  assign w_drop = r_xl_valid && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
      r_ovf <= w_drop;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= r_xl_char;
  end

  assign char_out       = r_mem[r_rd];
  assign char_valid_out = (r_count != '0);
  assign count_out      = r_count;
  assign overflow_out   = r_ovf;

endmodule

// File: tb/tb_keypress_decoder.sv
// Randomized scoreboard bench for keypress_decoder.
// A queue-based keyboard model predicts emitted characters; a monitor compares pops.
module tb_keypress_decoder;
  localparam int CW = 16;
  localparam int DEPTH = 8;
  localparam int UOFF = 64;
  localparam int TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid_in = 1'b0;
  logic [CW-1:0] char_out;
  logic          char_valid_out;
  logic          char_ready_in = 1'b1;
  logic          overflow_out;
  logic          shift_out;
  logic          caps_out;
  logic [3:0]    count_out;

  keypress_decoder #(
    .CHAR_WIDTH(CW), .FIFO_DEPTH(DEPTH),
    .UPPER_OFFSET(UOFF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .char_out(char_out), .char_valid_out(char_valid_out),
    .char_ready_in(char_ready_in), .overflow_out(overflow_out),
    .shift_out(shift_out), .caps_out(caps_out), .count_out(count_out)
  );

  int checks = 0;
  int errors = 0;
  int expq[$];
  int ovf_seen = 0;
  int exp_ovf = 0;
  int cyc = 0;
  int last_strobe = 0;
  bit rnd_ready = 1'b0;
  bit ready_force = 1'b1;

  bit m_ext, m_brk, m_shl, m_shr, m_caps, m_held, m_stall;

  logic [7:0] letters [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] misc [14] = '{
    8'h54, 8'h5B, 8'h41, 8'h49, 8'h4A, 8'h29, 8'h5A, 8'h66,
    8'h05, 8'h06, 8'h0E, 8'h76, 8'h75, 8'h72};
  logic [7:0] mods [3] = '{8'h12, 8'h59, 8'h58};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(logic [7:0] b, bit up, bit sh);
    for (int i = 0; i < 26; i++)
      if (letters[i] == b) return up ? i + 1 + UOFF : i + 1;
    for (int d = 0; d < 10; d++)
      if (digits[d] == b) return (d == 0) ? 44 : 34 + d;
    case (b)
      8'h54: return 29;
      8'h5B: return 30;
      8'h41: return 32;
      8'h49: return 33;
      8'h4A: return sh ? 31 : 47;
      8'h29: return 0;
      8'h5A: return 48;
      8'h66: return 27;
      8'h05: return 49;
      8'h06: return 50;
      default: return -1;
    endcase
  endfunction

  task automatic exp_push(int c);
    if (m_stall && expq.size() >= DEPTH) exp_ovf++;
    else expq.push_back(c);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
    m_caps = 0; m_held = 0;
    expq.delete();
  endtask

  task automatic model_byte(logic [7:0] b);
    int c;
    // Idle edges between this strobe and the previous one.
    if (cyc - last_strobe - 1 >= TMO) begin
      m_ext = 0;
      m_brk = 0;
    end
    last_strobe = cyc;
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12) m_shl = 0;
        if (b == 8'h59) m_shr = 0;
        if (b == 8'h58) m_held = 0;
      end
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        m_ext = 0;
        if (b == 8'h75) exp_push(49);
        else if (b == 8'h72) exp_push(50);
      end
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'h12) m_shl = 1;
    else if (b == 8'h59) m_shr = 1;
    else if (b == 8'h58) begin
      if (!m_held) m_caps = ~m_caps;
      m_held = 1;
    end else begin
      c = lookup(b, (m_shl | m_shr) ^ m_caps, m_shl | m_shr);
      if (c >= 0) exp_push(c);
    end
  endtask

  task automatic send(logic [7:0] b);
    byte_in = b;
    byte_valid_in = 1'b1;
    model_byte(b);
    @(negedge clk);
    byte_valid_in = 1'b0;
    chk("shift", shift_out, m_shl | m_shr);
    chk("caps", caps_out, m_caps);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 300 && (count_out != 0 || char_valid_out); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_pending", expq.size(), 0);
  endtask

  initial begin
    char_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (overflow_out === 1'b1) ovf_seen++;
      if (char_valid_out === 1'b1 && char_ready_in === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0d expected none", char_out);
        end else begin
          e = expq.pop_front();
          chk("char", char_out, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    model_reset();
    m_stall = 0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    chk("rst_valid", char_valid_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_shift", shift_out, 0);
    chk("rst_caps", caps_out, 0);

    // Two-cycle latency into an empty FIFO.
    byte_in = 8'h1C;
    byte_valid_in = 1'b1;
    model_byte(8'h1C);
    @(negedge clk);
    byte_valid_in = 1'b0;
    chk("lat_edge1", char_valid_out, 0);
    @(negedge clk);
    chk("lat_edge2", char_valid_out, 1);
    chk("lat_char", char_out, 1);
    repeat (2) @(negedge clk);
    chk("pop_count", count_out, 0);

    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    drain();

    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h15);
    send(8'h12); send(8'h15); send(8'hF0); send(8'h12);
    send(8'h4A); send(8'h16);
    send(8'h58); send(8'hF0); send(8'h58);
    drain();

    send(8'hE0); send(8'h75); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h1C);
    drain();

    // Stall the consumer and overfill by one.
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    m_stall = 1;
    for (int i = 0; i < DEPTH + 1; i++) send(8'h16);
    repeat (4) @(negedge clk);
    chk("full_count", count_out, DEPTH);
    chk("ovf_pulses", ovf_seen, exp_ovf);
    chk("ovf_once", ovf_seen, 1);
    m_stall = 0;
    ready_force = 1'b1;
    send(8'h16);
    @(negedge clk);
    chk("full_pushpop_count", count_out, DEPTH);
    drain();
    chk("ovf_after_pushpop", ovf_seen, 1);

    // Prefix abandoned after the timeout; just short of it, it is kept.
    send(8'hF0);
    repeat (TMO + 5) @(negedge clk);
    send(8'h1C);
    send(8'hF0);
    repeat (TMO - 3) @(negedge clk);
    send(8'h1C);
    send(8'hE0);
    repeat (TMO) @(negedge clk);
    send(8'h75);
    drain();

    // Reset discards prefix, modifiers, in-flight work.
    send(8'h12); send(8'h58); send(8'hE0);
    rst_in = 1'b1;
    byte_in = 8'h1C;
    byte_valid_in = 1'b1;
    @(negedge clk);
    byte_valid_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst2_valid", char_valid_out, 0);
    chk("rst2_count", count_out, 0);
    chk("rst2_ovf", overflow_out, 0);
    chk("rst2_shift", shift_out, 0);
    chk("rst2_caps", caps_out, 0);
    send(8'h75);
    send(8'h1C);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    model_reset();
    @(negedge clk);
    chk("inflight_drop", char_valid_out, 0);
    drain();

    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (k = 0; k < 100 && count_out > DEPTH - 3; k++) @(negedge clk);
      if (k == 100) chk("flow_wait", count_out, DEPTH - 3);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send(letters[$urandom_range(0, 25)]);
        4:          send(digits[$urandom_range(0, 9)]);
        5, 9:       send(misc[$urandom_range(0, 13)]);
        6:          send(8'hF0);
        7:          send(8'hE0);
        default:    send(mods[$urandom_range(0, 2)]);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("rand_ovf", ovf_seen, exp_ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
